onenot_checksum: RTL and testbench
==================================

ONENOT_CHECKSUM -- requirements
Module: onenot

Interface
REQ-001 Parameter WIDTH, default 16, data width of every operand and the result; the function requirements and verification values below assume WIDTH=16.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operands A..I are valid and sampled this cycle.
REQ-006 A  input  WIDTH  operand word 0.
REQ-007 B  input  WIDTH  operand word 1.
REQ-008 C  input  WIDTH  operand word 2.
REQ-009 D  input  WIDTH  operand word 3.
REQ-010 E  input  WIDTH  operand word 4.
REQ-011 F  input  WIDTH  operand word 5.
REQ-012 G  input  WIDTH  operand word 6.
REQ-013 H  input  WIDTH  operand word 7.
REQ-014 I  input  WIDTH  operand word 8.
REQ-015 y  output  WIDTH  registered one's-complement of the one's-complement sum of A..I.
REQ-016 out_valid  output  1  y holds a new result this cycle.

Function
REQ-017 Raw sum: S = A+B+C+D+E+F+G+H+I, unsigned, computed at WIDTH+4 bits (20 bits at WIDTH=16) so no carry is lost (max 9*0xFFFF = 0x8FFF7).
REQ-018 End-around carry: T1 = S[15:0] + S[19:16]; T2 = T1[15:0] + T1[16]; T2 is always 16 bits after the second fold.
REQ-019 Result: y_next = ~T2 (bitwise NOT, 16 bits).
REQ-020 Latency: exactly 1 cycle; operands sampled at edge k with in_valid=1 give y and out_valid=1 after edge k, visible in cycle k+1.
REQ-021 out_valid = in_valid registered, i.e. high for exactly one cycle per accepted operand set.
REQ-022 Back-to-back: in_valid high on consecutive cycles gives one result per cycle, no bubbles, no stalls; there is no backpressure.
REQ-023 When in_valid=0, y holds its last value and out_valid=0.
REQ-024 Zero representations: sum folding to 0x0000 gives y=0xFFFF; sum folding to 0xFFFF gives y=0x0000; both are legal, and no normalisation is applied.
REQ-025 Operands are treated as plain unsigned words; there is no dependence on bit patterns (thermometer or otherwise).
REQ-026 The datapath is combinational from inputs to one output register stage; there are no other state elements.

Reset
REQ-027 On a clk edge with rst=1: y <= 0x0000, out_valid <= 0, regardless of in_valid.
REQ-028 If rst and in_valid are both high, the operands are discarded and no result is produced.
REQ-029 The first valid result after reset appears one cycle after the first edge with rst=0 and in_valid=1.

Verification
REQ-030 A=0x001F B=0x00FF C=0x000F D=0x03FF E=0x3FFF F=0x01FF G=0x003F H=0x1FFF I=0x0003, in_valid=1 -> next cycle y=0x9894, out_valid=1 (S=0x676B, no carry).
REQ-031 All operands 0xFFFF -> S=0x8FFF7, fold gives 0xFFFF, y=0x0000.
REQ-032 A=0xFFFF, B=0x0001, rest 0 -> S=0x10000, fold gives 0x0001, y=0xFFFE (checks the end-around carry).
REQ-033 All operands 0x0000 -> y=0xFFFF.
REQ-034 Three back-to-back valid sets, then in_valid=0 -> three consecutive results, then out_valid=0 with y holding the third result.
REQ-035 Assert rst while in_valid=1 mid-stream -> next cycle y=0x0000, out_valid=0; operation resumes normally after rst drops.

Source files
------------

// File: rtl/onenot_checksum.sv
// Nine-operand one's-complement checksum: y is the inverted end-around-carry
// sum of A..I, registered one cycle after the operands are accepted.
module onenot_checksum #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] F,
    input  logic [WIDTH-1:0] G,
    input  logic [WIDTH-1:0] H,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] y,
    output logic             out_valid
);

    localparam int SUM_W = WIDTH + 4;

    // Two folds always suffice: the first leaves at most one carry bit,
    // and folding that carry back in cannot overflow again.
    function automatic logic [WIDTH-1:0] ones_fold(input logic [SUM_W-1:0] s);
        logic [WIDTH:0]   t1;
        logic [WIDTH-1:0] t2;
        t1 = {1'b0, s[WIDTH-1:0]} + {{(WIDTH-3){1'b0}}, s[SUM_W-1:WIDTH]};
        t2 = t1[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, t1[WIDTH]};
        return t2;
    endfunction

    function automatic logic [SUM_W-1:0] ext(input logic [WIDTH-1:0] w);
        return {4'b0000, w};
    endfunction

    logic [SUM_W-1:0] sum_s;
    logic [WIDTH-1:0] y_next_s;
    logic [WIDTH-1:0] y_r;
    logic             valid_r;

    // Full-precision raw sum and inverted folded result.
    always_comb begin
        sum_s    = ext(A) + ext(B) + ext(C) + ext(D) + ext(E)
                 + ext(F) + ext(G) + ext(H) + ext(I);
        y_next_s = ~ones_fold(sum_s);
    end

    // Output register: reset discards any operands presented alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_r     <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else begin
            valid_r <= in_valid;
            if (in_valid) begin
                y_r <= y_next_s;
            end else begin
                y_r <= y_r;
            end
        end
    end

    assign y         = y_r;
    assign out_valid = valid_r;

endmodule

// File: tb/tb_onenot_checksum.sv
// Directed self-checking bench for onenot_checksum with hand-computed results.
module tb_onenot_checksum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] A, B, C, D, E, F, G, H, I;
    logic [15:0] y;
    logic        out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    onenot_checksum #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H), .I(I),
        .y(y), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                           input logic [15:0] d, input logic [15:0] e, input logic [15:0] f,
                           input logic [15:0] g, input logic [15:0] h, input logic [15:0] i);
        A = a; B = b; C = c; D = d; E = e; F = f; G = g; H = h; I = i;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] ey, input logic ev);
        check_val({tag, "_y"}, {16'h0000, y}, {16'h0000, ey});
        check_val({tag, "_vld"}, {31'd0, out_valid}, {31'd0, ev});
    endtask

    task automatic set_ref();
        set_ops(16'h001F, 16'h00FF, 16'h000F, 16'h03FF, 16'h3FFF,
                16'h01FF, 16'h003F, 16'h1FFF, 16'h0003);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        set_ref();
        step();
        step();
        expect_out("reset", 16'h0000, 1'b0);

        rst = 1'b0;
        in_valid = 1'b0;
        step();
        expect_out("idle_after_reset", 16'h0000, 1'b0);

        in_valid = 1'b1;
        set_ref();
        step();
        expect_out("ref_vector", 16'h9894, 1'b1);

        in_valid = 1'b0;
        set_ops(16'h1111, 16'h2222, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        step();
        expect_out("hold_idle", 16'h9894, 1'b0);

        in_valid = 1'b1;
        set_ops(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        step();
        expect_out("all_ones", 16'h0000, 1'b1);

        set_ops(16'hFFFF, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        step();
        expect_out("end_carry", 16'hFFFE, 1'b1);

        set_ops(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        step();
        expect_out("all_zero", 16'hFFFF, 1'b1);

        set_ops(16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        step();
        expect_out("neg_zero", 16'h0000, 1'b1);

        // 3*0xFFFF + 2 = 0x2FFFF: first fold carries out, second fold gives 0x0002.
        set_ops(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0002, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        step();
        expect_out("second_fold", 16'hFFFD, 1'b1);

        set_ref();
        step();
        expect_out("b2b_1", 16'h9894, 1'b1);
        set_ops(16'h1234, 16'h8765, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        step();
        expect_out("b2b_2", 16'h6666, 1'b1);
        set_ops(16'h8000, 16'h8000, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        step();
        expect_out("b2b_3", 16'hFFFD, 1'b1);
        in_valid = 1'b0;
        step();
        expect_out("b2b_drain", 16'hFFFD, 1'b0);
        step();
        expect_out("b2b_hold", 16'hFFFD, 1'b0);

        in_valid = 1'b1;
        set_ops(16'h1234, 16'h8765, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        step();
        expect_out("pre_rst", 16'h6666, 1'b1);
        rst = 1'b1;
        set_ref();
        step();
        expect_out("mid_rst", 16'h0000, 1'b0);
        rst = 1'b0;
        set_ops(16'h8000, 16'h8000, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        step();
        expect_out("post_rst", 16'hFFFD, 1'b1);
        in_valid = 1'b0;
        step();
        expect_out("post_rst_idle", 16'hFFFD, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
